// File: rtl/pcie_row_loader.sv
// Loads the HWC-ordered PCIe image stream into a circular row buffer, generating
// write addresses and tracking resident complete rows for the conv PE array.
module pcie_row_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 227,
    parameter int IMG_H      = 227,
    parameter int IMG_C      = 3,
    parameter int ROW_SLOTS  = 12,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic [3:0]            rows_ready,
    output logic [3:0]            rd_slot,
    input  logic                  row_release,
    output logic                  release_err,
    output logic                  finish
);

    localparam int CH_W  = (IMG_C > 1) ? $clog2(IMG_C) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [3:0]            r_wr_slot;
    logic [3:0]            r_rd_slot;
    logic [3:0]            r_rows_ready;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_release_err;
    logic                  r_finish;

    logic                  w_ch_last;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_row_done;
    logic                  w_rel_ok;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_ch_last  = (r_ch == CH_W'(IMG_C - 1));
    assign w_col_last = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
    assign w_in_ready = (r_state == ST_LOAD) && enable && (r_rows_ready < 4'(ROW_SLOTS));
    assign w_accept   = in_valid && w_in_ready;
    assign w_row_done = w_accept && w_ch_last && w_col_last;
    assign w_rel_ok   = row_release && (r_rows_ready != '0);
    assign w_addr     = ADDR_WIDTH'(r_wr_slot) * ADDR_WIDTH'(IMG_W * IMG_C)
                      + ADDR_WIDTH'(r_col) * ADDR_WIDTH'(IMG_C)
                      + ADDR_WIDTH'(r_ch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ch          <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_wr_slot     <= '0;
            r_rd_slot     <= '0;
            r_rows_ready  <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_release_err <= 1'b0;
            r_finish      <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_addr;
                r_wr_data <= in_data;
                if (w_ch_last) begin
                    r_ch <= '0;
                    if (w_col_last) begin
                        r_col     <= '0;
                        r_row     <= w_row_last ? '0 : r_row + 1'b1;
                        r_wr_slot <= (r_wr_slot == 4'(ROW_SLOTS - 1)) ? '0 : r_wr_slot + 4'd1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end

            if (w_rel_ok)
                r_rd_slot <= (r_rd_slot == 4'(ROW_SLOTS - 1)) ? '0 : r_rd_slot + 4'd1;
            case ({w_row_done, w_rel_ok})
                2'b10:   r_rows_ready <= r_rows_ready + 4'd1;
                2'b01:   r_rows_ready <= r_rows_ready - 4'd1;
                default: ;
            endcase
            if (row_release && (r_rows_ready == '0))
                r_release_err <= 1'b1;

            // The start clears below are placed last so they win over the release updates above.
            case (r_state)
                ST_IDLE: if (enable) begin
                    r_state       <= ST_LOAD;
                    r_ch          <= '0;
                    r_col         <= '0;
                    r_row         <= '0;
                    r_wr_slot     <= '0;
                    r_rd_slot     <= '0;
                    r_rows_ready  <= '0;
                    r_release_err <= 1'b0;
                end
                ST_LOAD: if (w_row_done && w_row_last) begin
                    r_state  <= ST_DONE;
                    r_finish <= 1'b1;
                end
                ST_DONE: if (!enable) begin
                    r_state  <= ST_IDLE;
                    r_finish <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign buf_wr_en   = r_wr_en;
    assign buf_wr_addr = r_wr_addr;
    assign buf_wr_data = r_wr_data;
    assign rows_ready  = r_rows_ready;
    assign rd_slot     = r_rd_slot;
    assign release_err = r_release_err;
    assign finish      = r_finish;

endmodule
